drain_scheduler: RTL and testbench
==================================

# drain_scheduler

Sequences two drain pumps that share the outflow channel of the flood-control datapath. It samples the 4-bit water level on the 1 Hz tick and starts the lead pump when the level reaches the high threshold. It adds the lag pump at the critical level and enforces minimum on and off times. It alternates the lead pump after every drain cycle to share wear. Its outputs drive the existing pump-speed and water-level drain logic in place of a single hard-wired pump.

## Interface
- `HIGH_LVL`, default 12: start-drain threshold, inclusive.
- `CRIT_LVL`, default 14: lag-pump threshold, inclusive.
- `SAFE_LVL`, default 6: stop threshold, inclusive.
- `MIN_ON`, default 3: minimum ticks in a pumping state before stopping.
- `MIN_OFF`, default 2: ticks spent in COOLDOWN.
- `ALARM_TICKS`, default 4: consecutive ticks at level 15 in PUMP_TWO before the alarm is raised.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `tick` input 1: 1 Hz single-cycle enable from the 1 Hz clock generator.
- `water_level` input 4: current level, 0–15.
- `manual_req` input 1: debounced single-cycle manual-drain pulse.
- `pump_en` output 2: bit0 is pump A, bit1 is pump B.
- `pump_speed` output 2: 0 = off, 1 = slow, 2 = medium, 3 = fast.
- `lead` output 1: 0 means A leads, 1 means B leads.
- `alarm` output 1: sticky overflow alarm.
- `state` output 3: current FSM state, for display.

## Operation
- **States:** IDLE=0, PUMP_ONE=1, PUMP_TWO=2, COOLDOWN=3. Encodings 4–7 are illegal and go to IDLE.
- **Evaluation timing:** all transitions, counters and `water_level` sampling happen only on clk edges where `tick`=1. `manual_req` is the only input acted on at any cycle.
- **IDLE:**
  - `level>=HIGH_LVL` goes to PUMP_ONE.
  - Otherwise, if `manual_req` was latched since the last tick and `level>SAFE_LVL`, go to PUMP_ONE.
  - Otherwise stay in IDLE.
  - `manual_req` is latched into a pending flag. The flag clears when consumed on a tick, and also on any tick where `level<=SAFE_LVL`.
- **PUMP_ONE:** only the lead pump is on.
  - `level>=CRIT_LVL` goes to PUMP_TWO.
  - Otherwise, `level<=SAFE_LVL` and `on_cnt>=MIN_ON` goes to COOLDOWN.
- **PUMP_TWO:** both pumps are on.
  - `level<=SAFE_LVL` and `on_cnt>=MIN_ON` goes to COOLDOWN. This check has priority.
  - Otherwise, `level<HIGH_LVL` goes to PUMP_ONE.
- **COOLDOWN:** both pumps are off.
  - `off_cnt` counts ticks.
  - When `off_cnt==MIN_OFF-1` on a tick, go to IDLE.
  - Threshold crossings are ignored until then.
- **on_cnt:**
  - Clears on entry to PUMP_ONE from IDLE.
  - Does not clear on PUMP_ONE↔PUMP_TWO moves.
  - Increments on every tick in either pumping state and saturates at `MIN_ON`.
- **lead:** toggles on each transition into COOLDOWN.
- **pump_speed:**
  - IDLE and COOLDOWN: 0.
  - PUMP_ONE: 1 if `level<HIGH_LVL`, else 2.
  - PUMP_TWO: 3.
  - Recomputed from the level sampled on each tick.
- **pump_en:** PUMP_ONE gives `lead ? 2'b10 : 2'b01`. PUMP_TWO gives `2'b11`. IDLE and COOLDOWN give `2'b00`.
- **alarm:**
  - `alarm_cnt` increments on ticks with state PUMP_TWO and `level==15`, and clears on any other tick.
  - Reaching `ALARM_TICKS` sets `alarm`.
  - `alarm` clears only on reset or on a tick with `level<=SAFE_LVL`.
- **Arithmetic:** all comparisons are 4-bit unsigned. Counters are sized `$clog2(max+1)` and never wrap.

## Timing
- All outputs are registered. They change on the same edge where `tick` is sampled high, so there is one cycle of latency from the tick cycle.
- Reset values: `state`=IDLE, `pump_en`=0, `pump_speed`=0, `lead`=0, `alarm`=0, all counters and the pending flag 0.
- Reset is asynchronous on assertion. It is released synchronously via a two-flop synchronizer inside the block.
- Reset mid-drain turns pumps off immediately, with no cooldown.
- `manual_req` and `tick` in the same cycle: the request counts for that tick.

## Structure
- Shared header `flood_defs.vh`: state encodings, speed codes (`SPD_OFF`/`SLOW`/`MED`/`FAST`), default thresholds.
- One sub-module, `pump_timer`: a tick-enabled saturating counter with `clr`, `en` and `done` (`count>=LIMIT`). It is instantiated twice, for `on_cnt` and `off_cnt`.
- Alarm counter and request latch stay inline.

## Test plan
- **Normal drain:** level 12 on tick → PUMP_ONE, `pump_en`=01, speed 2. Level 6 after 3 ticks → COOLDOWN, `lead`=1. After 2 ticks → IDLE.
- **Min-on hold:** level 12, then level 5 on the next tick → stays in PUMP_ONE until the third tick, then COOLDOWN.
- **Escalation:** level 14 during PUMP_ONE → PUMP_TWO, `pump_en`=11, speed 3. Level 11 → PUMP_ONE with the lead pump only, speed 1.
- **Manual request:** level 8 in IDLE plus `manual_req` → PUMP_ONE on the next tick. At level 6, `manual_req` is ignored and pending clears.
- **Alarm:** level 15 held 4 ticks in PUMP_TWO → `alarm`=1. It stays 1 at level 10 and clears at level 6.
- **Async reset:** `rst` low mid-PUMP_TWO → `pump_en`=0, `state`=0 within the same cycle, with no clk edge needed.

Source files
------------

// File: rtl/drain_scheduler_pkg.sv
// Shared encodings for the drain pump scheduler: FSM states, pump speed codes
// and default level/timing thresholds.
package drain_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUMP_ONE = 3'd1,
        ST_PUMP_TWO = 3'd2,
        ST_COOLDOWN = 3'd3
    } state_e;

    localparam logic [1:0] SPD_OFF  = 2'd0;
    localparam logic [1:0] SPD_SLOW = 2'd1;
    localparam logic [1:0] SPD_MED  = 2'd2;
    localparam logic [1:0] SPD_FAST = 2'd3;

    localparam logic [3:0]  DEF_HIGH_LVL    = 4'd12;
    localparam logic [3:0]  DEF_CRIT_LVL    = 4'd14;
    localparam logic [3:0]  DEF_SAFE_LVL    = 4'd6;
    localparam int unsigned DEF_MIN_ON      = 3;
    localparam int unsigned DEF_MIN_OFF     = 2;
    localparam int unsigned DEF_ALARM_TICKS = 4;

endpackage

// File: rtl/drain_scheduler_pump_timer.sv
// Tick-enabled saturating counter; done_o reports that the count including
// this cycle's tick has reached LIMIT, so it can gate a transition on that tick.
module pump_timer #(
    parameter int unsigned LIMIT = 3
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic tick_i,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (tick_i) begin
            if (clr_i) begin
                count_d = '0;
            end else if (en_i && (count_q < W'(LIMIT))) begin
                count_d = count_q + W'(1);
            end
        end
    end

    assign done_o = (count_d >= W'(LIMIT));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/drain_scheduler.sv
// Lead/lag drain pump sequencer evaluated on the 1 Hz tick; all outputs are
// registered and update on the tick edge. Reset asserts asynchronously.
module drain_scheduler
    import drain_scheduler_pkg::*;
#(
    parameter logic [3:0]  HIGH_LVL    = DEF_HIGH_LVL,
    parameter logic [3:0]  CRIT_LVL    = DEF_CRIT_LVL,
    parameter logic [3:0]  SAFE_LVL    = DEF_SAFE_LVL,
    parameter int unsigned MIN_ON      = DEF_MIN_ON,
    parameter int unsigned MIN_OFF     = DEF_MIN_OFF,
    parameter int unsigned ALARM_TICKS = DEF_ALARM_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] water_level,
    input  logic       manual_req,
    output logic [1:0] pump_en,
    output logic [1:0] pump_speed,
    output logic       lead,
    output logic       alarm,
    output logic [2:0] state
);

    localparam int unsigned AW = $clog2(ALARM_TICKS + 1);

    logic [1:0]    rst_sync_q;
    logic          rst_n_int;
    state_e        state_q, state_d;
    logic          pend_q, pend_d, pend_eff;
    logic          lead_q, lead_d;
    logic          alarm_q, alarm_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic [1:0]    en_q, en_d, spd_q, spd_d;
    logic          on_done, off_done;
    logic          safe;

    // Assert immediately, release two clock edges after rst deasserts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n_int = rst_sync_q[1];

    pump_timer #(.LIMIT(MIN_ON)) u_on_timer (
        .clk_i   (clk),
        .rst_n_i (rst_n_int),
        .tick_i  (tick),
        .clr_i   (state_q == ST_IDLE),
        .en_i    ((state_q == ST_PUMP_ONE) || (state_q == ST_PUMP_TWO)),
        .done_o  (on_done)
    );

    pump_timer #(.LIMIT(MIN_OFF)) u_off_timer (
        .clk_i   (clk),
        .rst_n_i (rst_n_int),
        .tick_i  (tick),
        .clr_i   (state_q != ST_COOLDOWN),
        .en_i    (state_q == ST_COOLDOWN),
        .done_o  (off_done)
    );

    assign safe     = (water_level <= SAFE_LVL);
    assign pend_eff = pend_q | manual_req;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_eff;
        lead_d      = lead_q;
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;
        en_d        = en_q;
        spd_d       = spd_q;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if ((water_level >= HIGH_LVL) || (pend_eff && !safe)) begin
                        state_d = ST_PUMP_ONE;
                        pend_d  = 1'b0;
                    end
                end
                ST_PUMP_ONE: begin
                    if (water_level >= CRIT_LVL) begin
                        state_d = ST_PUMP_TWO;
                    end else if (safe && on_done) begin
                        state_d = ST_COOLDOWN;
                    end
                end
                ST_PUMP_TWO: begin
                    if (safe && on_done) begin
                        state_d = ST_COOLDOWN;
                    end else if (water_level < HIGH_LVL) begin
                        state_d = ST_PUMP_ONE;
                    end
                end
                ST_COOLDOWN: begin
                    if (off_done) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if ((state_d == ST_COOLDOWN) && (state_q != ST_COOLDOWN)) begin
                lead_d = ~lead_q;
            end
            if (safe) begin
                pend_d = 1'b0;
            end

            if ((state_q == ST_PUMP_TWO) && (water_level == 4'd15)) begin
                if (alarm_cnt_q < AW'(ALARM_TICKS)) begin
                    alarm_cnt_d = alarm_cnt_q + AW'(1);
                end
            end else begin
                alarm_cnt_d = '0;
            end
            if (alarm_cnt_d == AW'(ALARM_TICKS)) begin
                alarm_d = 1'b1;
            end
            if (safe) begin
                alarm_d = 1'b0;
            end

            case (state_d)
                ST_PUMP_ONE: begin
                    en_d  = lead_d ? 2'b10 : 2'b01;
                    spd_d = (water_level < HIGH_LVL) ? SPD_SLOW : SPD_MED;
                end
                ST_PUMP_TWO: begin
                    en_d  = 2'b11;
                    spd_d = SPD_FAST;
                end
                default: begin
                    en_d  = 2'b00;
                    spd_d = SPD_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            lead_q      <= 1'b0;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
            en_q        <= 2'b00;
            spd_q       <= SPD_OFF;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            lead_q      <= lead_d;
            alarm_q     <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
            en_q        <= en_d;
            spd_q       <= spd_d;
        end
    end

    assign pump_en    = en_q;
    assign pump_speed = spd_q;
    assign lead       = lead_q;
    assign alarm      = alarm_q;
    assign state      = state_q;

endmodule

// File: tb/tb_drain_scheduler.sv
// Directed drain scenarios followed by a random level walk, each tick checked
// against a behavioural model of the pump sequencing rules.
module tb_drain_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] water_level = 4'd0;
    logic       manual_req = 1'b0;
    logic [1:0] pump_en;
    logic [1:0] pump_speed;
    logic       lead;
    logic       alarm;
    logic [2:0] state;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: state 0 idle, 1 one pump, 2 two pumps, 3 cooldown.
    int m_state, m_pump_ticks, m_cool_ticks, m_hi_run, m_lvl;
    bit m_lead, m_pend, m_alarm;

    drain_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .water_level (water_level),
        .manual_req  (manual_req),
        .pump_en     (pump_en),
        .pump_speed  (pump_speed),
        .lead        (lead),
        .alarm       (alarm),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_pump_ticks = 0; m_cool_ticks = 0; m_hi_run = 0;
        m_lvl = 0; m_lead = 0; m_pend = 0; m_alarm = 0;
    endtask

    task automatic model_tick(input int lvl, input bit mreq);
        int prev;
        bit req;
        prev = m_state;
        req  = m_pend | mreq;
        case (prev)
            0: if (lvl >= 12 || (req && lvl > 6)) begin
                   m_state = 1; m_pump_ticks = 0; req = 0;
               end
            1: begin
                   m_pump_ticks++;
                   if (lvl >= 14) m_state = 2;
                   else if (lvl <= 6 && m_pump_ticks >= 3) m_state = 3;
               end
            2: begin
                   m_pump_ticks++;
                   if (lvl <= 6 && m_pump_ticks >= 3) m_state = 3;
                   else if (lvl < 12) m_state = 1;
               end
            default: begin
                   m_cool_ticks++;
                   if (m_cool_ticks >= 2) m_state = 0;
               end
        endcase
        if (m_state == 3 && prev != 3) begin
            m_lead = ~m_lead;
            m_cool_ticks = 0;
        end
        m_pend   = (lvl <= 6) ? 1'b0 : req;
        m_hi_run = (prev == 2 && lvl == 15) ? m_hi_run + 1 : 0;
        if (m_hi_run >= 4) m_alarm = 1;
        if (lvl <= 6) m_alarm = 0;
        m_lvl = lvl;
    endtask

    function automatic logic [7:0] exp_speed();
        if (m_state == 1) return (m_lvl < 12) ? 8'd1 : 8'd2;
        if (m_state == 2) return 8'd3;
        return 8'd0;
    endfunction

    function automatic logic [7:0] exp_en();
        if (m_state == 1) return m_lead ? 8'd2 : 8'd1;
        if (m_state == 2) return 8'd3;
        return 8'd0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, {5'd0, state}, 8'(m_state));
        chk({tag, ".pump_en"}, {6'd0, pump_en}, exp_en());
        chk({tag, ".pump_speed"}, {6'd0, pump_speed}, exp_speed());
        chk({tag, ".lead"}, {7'd0, lead}, {7'd0, m_lead});
        chk({tag, ".alarm"}, {7'd0, alarm}, {7'd0, m_alarm});
    endtask

    task automatic step(input string tag, input int lvl, input bit mreq);
        @(negedge clk);
        tick = 1'b1;
        water_level = 4'(lvl);
        manual_req = mreq;
        @(posedge clk);
        #1;
        tick = 1'b0;
        manual_req = 1'b0;
        model_tick(lvl, mreq);
        check_all(tag);
    endtask

    // Idle cycles between ticks, optionally carrying manual request pulses.
    task automatic gap(input int n, input bit allow_req);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            manual_req = allow_req && ($urandom_range(0, 5) == 0);
            if (manual_req) m_pend = 1'b1;
            water_level = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            manual_req = 1'b0;
        end
    endtask

    task automatic pulse_req();
        @(negedge clk);
        manual_req = 1'b1;
        m_pend = 1'b1;
        @(posedge clk);
        #1;
        manual_req = 1'b0;
    endtask

    initial begin
        int lvl;
        model_reset();
        #23;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");

        // Normal drain
        step("nd_start", 12, 0);
        gap(2, 0);
        step("nd_t1", 10, 0);
        step("nd_t2", 10, 0);
        step("nd_t3", 6, 0);
        step("nd_cool1", 13, 0);
        step("nd_cool2", 6, 0);

        // Minimum on-time hold with the new lead pump
        step("mo_start", 12, 0);
        step("mo_t1", 5, 0);
        step("mo_t2", 5, 0);
        step("mo_t3", 5, 0);
        step("mo_cool1", 5, 0);
        step("mo_cool2", 5, 0);

        // Escalation and de-escalation
        step("es_start", 12, 0);
        step("es_crit", 14, 0);
        step("es_back", 11, 0);
        step("es_stop", 6, 0);
        step("es_cool1", 6, 0);
        step("es_cool2", 6, 0);

        // Manual request latched between ticks, then request ignored at safe level
        pulse_req();
        gap(2, 0);
        step("mr_start", 8, 0);
        step("mr_t1", 6, 0);
        step("mr_t2", 6, 0);
        step("mr_t3", 6, 0);
        step("mr_cool1", 6, 0);
        step("mr_cool2", 6, 0);
        step("mr_safe", 6, 1);
        step("mr_nopend", 8, 0);
        step("mr_same", 9, 1);
        step("mr2_t1", 6, 0);
        step("mr2_t2", 6, 0);
        step("mr2_t3", 6, 0);
        step("mr2_cool1", 6, 0);
        step("mr2_cool2", 6, 0);

        // Overflow alarm: sticky through level 10, cleared at safe level
        step("al_start", 12, 0);
        step("al_two", 15, 0);
        for (int i = 0; i < 4; i++) step("al_hold", 15, 0);
        step("al_sticky", 10, 0);
        step("al_clear", 6, 0);
        step("al_cool1", 6, 0);
        step("al_cool2", 6, 0);

        // Asynchronous reset in PUMP_TWO
        step("ar_start", 12, 0);
        step("ar_two", 14, 0);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("post_rst");

        // Random level walk
        lvl = 8;
        for (int i = 0; i < 400; i++) begin
            lvl = lvl + int'($urandom_range(0, 6)) - 3;
            if (lvl < 0) lvl = 0;
            if (lvl > 15) lvl = 15;
            gap(int'($urandom_range(0, 2)), 1'b1);
            step("rand", lvl, $urandom_range(0, 5) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
